// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch seven-segment display path.
// Contents: active-low glyph constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF),
// the anode-off pattern AN_OFF, the 2-bit digit index type and the
// slot-to-digit index constants (SEC_O=0, SEC_T=1, MIN_O=2, MIN_T=3).
package stopwatch_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam digit_idx_t SEC_O = 2'd0;
    localparam digit_idx_t SEC_T = 2'd1;
    localparam digit_idx_t MIN_O = 2'd2;
    localparam digit_idx_t MIN_T = 2'd3;

    // Cathode order {g,f,e,d,c,b,a}, 0 = segment lit
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [3:0] AN_OFF   = 4'b1111;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to seven-segment glyph decoder.
// Ports:
//   bcd  in  4  BCD digit; codes 10-15 render as a dash
//   seg  out 7  cathodes {g,f,e,d,c,b,a}, active-low
module bcd_to_seg
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/stopwatch_seg_display.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// One digit is lit per slot of REFRESH_DIV cycles; the first BLANK_CYC cycles
// of each slot keep all anodes off. All four digits are snapshotted once per
// frame so a frame never mixes two counter values.
// Optional feature macro STOPWATCH_BLINK_EN: blank the digit pair under
// adjustment while blink_clk is high; without it adj/sel/blink_clk are ignored.
// Ports:
//   clk        in   1  system clock
//   rst        in   1  asynchronous active-high reset
//   blink_clk  in   1  slow square wave, level-sampled through a 2-flop sync
//   adj        in   1  adjust mode active
//   sel        in   1  adjust target: 0 = minutes pair, 1 = seconds pair
//   min_t/min_o/sec_t/sec_o in 4  BCD digits
//   seg        out  7  cathodes {g,f,e,d,c,b,a}, active-low
//   an         out  4  anodes, active-low; an[3]=min_t ... an[0]=sec_o
//   dp         out  1  decimal point, active-low (lit on the minutes-ones slot)
module stopwatch_seg_display
    import stopwatch_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       blink_clk,
    input  logic       adj,
    input  logic       sel,
    input  logic [3:0] min_t,
    input  logic [3:0] min_o,
    input  logic [3:0] sec_t,
    input  logic [3:0] sec_o,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CntW-1:0]  slot_cnt_q;
    digit_idx_t       idx_q;
    logic [3:0][3:0]  snap_q;      // indexed by digit_idx_t
    logic             slot_wrap;
    logic             slot_dark;
    logic [6:0]       digit_seg;
    logic             blink_hide;
    logic [6:0]       seg_q;
    logic [3:0]       an_q, an_d;
    logic             dp_q, dp_d;

    assign slot_wrap = (slot_cnt_q == CntW'(REFRESH_DIV - 1));
    assign slot_dark = (slot_cnt_q < CntW'(BLANK_CYC));

    // Scan counter; the snapshot loads on the same edge that wraps idx 3 -> 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt_q <= '0;
            idx_q      <= SEC_O;
            snap_q     <= '0;
        end else if (slot_wrap) begin
            slot_cnt_q <= '0;
            idx_q      <= digit_idx_t'(idx_q + 2'd1);
            if (idx_q == MIN_T) begin
                snap_q <= {min_t, min_o, sec_t, sec_o};
            end
        end else begin
            slot_cnt_q <= slot_cnt_q + CntW'(1);
        end
    end

    bcd_to_seg u_bcd_to_seg (
        .bcd (snap_q[idx_q]),
        .seg (digit_seg)
    );

`ifdef STOPWATCH_BLINK_EN
    logic blink_meta_q, blink_s_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_meta_q <= 1'b0;
            blink_s_q    <= 1'b0;
        end else begin
            blink_meta_q <= blink_clk;
            blink_s_q    <= blink_meta_q;
        end
    end

    // sel=1 hides the seconds pair (idx 0,1), sel=0 the minutes pair (idx 2,3)
    assign blink_hide = adj & blink_s_q & (sel ? ~idx_q[1] : idx_q[1]);
`else
    logic unused_blink_inputs;
    assign unused_blink_inputs = ^{adj, sel, blink_clk};
    assign blink_hide          = 1'b0;
`endif

    always_comb begin
        an_d = AN_OFF;
        dp_d = 1'b1;
        if (!slot_dark) begin
            an_d = ~(4'b0001 << idx_q);
            dp_d = (idx_q != MIN_O);
            if (blink_hide) begin
                an_d = AN_OFF;
            end
        end
    end

    // Outputs trail slot_cnt/idx by one cycle; seg changes only at slot start,
    // which always falls inside the dark window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_OFF;
            an_q  <= AN_OFF;
            dp_q  <= 1'b1;
        end else begin
            an_q <= an_d;
            dp_q <= dp_d;
            if (slot_cnt_q == '0) begin
                seg_q <= digit_seg;
            end
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_stopwatch_seg_display.sv
// Self-checking bench for stopwatch_seg_display (REFRESH_DIV=8, BLANK_CYC=2).
// A reference model derives every output from the number of clock edges since
// reset and the inputs recorded at frame boundaries; table vectors and hand
// sequences cover the named corner cases.
module tb_stopwatch_seg_display;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;
    localparam int MAXE  = 16384;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       blink_clk = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] min_t = '0, min_o = '0, sec_t = '0, sec_o = '0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    stopwatch_seg_display #(
        .REFRESH_DIV (DIV),
        .BLANK_CYC   (BLANK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .blink_clk (blink_clk),
        .adj       (adj),
        .sel       (sel),
        .min_t     (min_t),
        .min_o     (min_o),
        .sec_t     (sec_t),
        .sec_o     (sec_o),
        .seg       (seg),
        .an        (an),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          e      = 0;           // rising edges since reset release
    logic [6:0]  glyph [16];
    logic [15:0] frame_snap [512];     // {min_t,min_o,sec_t,sec_o} captured per frame
    logic        blink_hist [MAXE];    // blink_clk level seen at each edge

    typedef struct {
        logic [3:0] mt, mo, st, so;
        logic [6:0] exp_seg [4];       // expected glyph per slot, [0]=sec_o
    } vec_t;
    vec_t vecs [4];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at e=%0d: got %b, expected %b", name, e, act, exp);
        end
    endtask

    task automatic check_model();
        logic [3:0]  an_e;
        logic [6:0]  seg_e;
        logic        dp_e;
        logic [15:0] fs;
        logic [3:0]  dig;
        int          m, cnt, ix, f;
        if (e == 0) begin
            an_e = 4'hF; seg_e = 7'h7F; dp_e = 1'b1;
        end else begin
            m   = e - 1;
            cnt = m % DIV;
            ix  = (m / DIV) % 4;
            f   = m / FRAME;
            fs  = (f == 0) ? 16'h0 : frame_snap[f];
            dig = fs[ix*4 +: 4];
            seg_e = glyph[dig];
            if (cnt < BLANK) begin
                an_e = 4'hF; dp_e = 1'b1;
            end else begin
                an_e = ~(4'b0001 << ix);
                dp_e = (ix != 2);
            end
`ifdef STOPWATCH_BLINK_EN
            begin
                logic bs;
                bs = (e >= 3) ? blink_hist[e-2] : 1'b0;
                if (adj && bs && ((sel && ix < 2) || (!sel && ix >= 2))) an_e = 4'hF;
            end
`endif
        end
        chk("model_an", {4'h0, an}, {4'h0, an_e});
        chk("model_seg", {1'b0, seg}, {1'b0, seg_e});
        chk("model_dp", {7'h0, dp}, {7'h0, dp_e});
    endtask

    task automatic step();
        @(posedge clk);
        e++;
        if (e < MAXE) blink_hist[e] = blink_clk;
        if (e % FRAME == 0 && e / FRAME < 512) frame_snap[e / FRAME] = {min_t, min_o, sec_t, sec_o};
        #1;
        check_model();
    endtask

    // Advance until e % FRAME == r (at most one frame).
    task automatic step_to(input int r);
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (e % FRAME == r) break;
        end
    endtask

    task automatic set_digits(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d);
        min_t = a; min_o = b; sec_t = c; sec_o = d;
    endtask

    // Lit-digit mask over one full frame starting at a frame boundary.
    task automatic frame_lit(output logic [3:0] lit);
        lit = 4'h0;
        step_to(0);
        for (int i = 0; i < FRAME; i++) begin
            step();
            lit = lit | ~an;
        end
    endtask

    initial begin
        logic [3:0] lit;
        glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                  7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111,
                  7'b0111111};
        vecs[0] = '{4'd1, 4'd2, 4'd3, 4'd4,
                    '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001}};
        vecs[1] = '{4'hC, 4'd9, 4'd0, 4'd7,
                    '{7'b1111000, 7'b1000000, 7'b0010000, 7'b0111111}};
        vecs[2] = '{4'd5, 4'd8, 4'd6, 4'hF,
                    '{7'b0111111, 7'b0000010, 7'b0000000, 7'b0010010}};
        vecs[3] = '{4'hA, 4'd0, 4'd5, 4'd9,
                    '{7'b0010000, 7'b0010010, 7'b1000000, 7'b0111111}};

        // Reset held with arbitrary inputs
        rst = 1'b1;
        set_digits(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        repeat (3) @(posedge clk);
        #1;
        chk("reset_an", {4'h0, an}, 8'h0F);
        chk("reset_seg", {1'b0, seg}, 8'h7F);
        chk("reset_dp", {7'h0, dp}, 8'h01);
        @(negedge clk);
        rst = 1'b0;
        e   = 0;

        // First slot: dark for two cycles, then digit 0 on an=1110
        step(); step();
        chk("first_dark_an", {4'h0, an}, 8'h0F);
        step();
        chk("first_lit_an", {4'h0, an}, 8'h0E);
        chk("first_lit_seg", {1'b0, seg}, 8'h40);

        // Table vectors: load, wait for the capturing frame, check each slot's first lit cycle
        foreach (vecs[v]) begin
            set_digits(vecs[v].mt, vecs[v].mo, vecs[v].st, vecs[v].so);
            step_to(0);
            for (int i = 0; i < FRAME; i++) begin
                step();
                if ((e - 1) % DIV == BLANK) begin
                    int ix;
                    ix = ((e - 1) / DIV) % 4;
                    chk($sformatf("vec%0d_seg_slot%0d", v, ix), {1'b0, seg},
                        {1'b0, vecs[v].exp_seg[ix]});
                    chk($sformatf("vec%0d_an_slot%0d", v, ix), {4'h0, an},
                        {4'h0, ~(4'b0001 << ix)});
                    chk($sformatf("vec%0d_dp_slot%0d", v, ix), {7'h0, dp},
                        {7'h0, (ix != 2)});
                end
            end
        end

        // sec_o changes mid-frame: current frame keeps the old snapshot
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        step_to(0);
        step_to(1 + BLANK);
        chk("midframe_old_seg", {1'b0, seg}, 8'h19);
        step_to(DIV + 3);
        sec_o = 4'd5;
        step_to(0);
        step_to(1 + BLANK);
        chk("midframe_new_seg", {1'b0, seg}, 8'h12);

        // Blink of the adjusted pair
        adj = 1'b1; sel = 1'b1; blink_clk = 1'b1;
        repeat (3) step();
        frame_lit(lit);
`ifdef STOPWATCH_BLINK_EN
        chk("blink_sec_pair", {4'h0, lit}, 8'h0C);
`else
        chk("blink_sec_pair", {4'h0, lit}, 8'h0F);
`endif
        sel = 1'b0;
        frame_lit(lit);
`ifdef STOPWATCH_BLINK_EN
        chk("blink_min_pair", {4'h0, lit}, 8'h03);
`else
        chk("blink_min_pair", {4'h0, lit}, 8'h0F);
`endif
        adj = 1'b0;
        frame_lit(lit);
        chk("blink_adj_off", {4'h0, lit}, 8'h0F);

        // Randomized run against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: min_t = 4'($urandom_range(0, 15));
                    1: min_o = 4'($urandom_range(0, 15));
                    2: sec_t = 4'($urandom_range(0, 15));
                    default: sec_o = 4'($urandom_range(0, 15));
                endcase
            end
            if ($urandom_range(0, 15) == 0) adj = 1'($urandom);
            if ($urandom_range(0, 15) == 0) sel = 1'($urandom);
            if ($urandom_range(0, 4) == 0) blink_clk = ~blink_clk;
            step();
        end

        // Asynchronous reset in the middle of slot 2
        adj = 1'b0;
        step_to(2 * DIV + 4);
        chk("pre_reset_an", {4'h0, an}, 8'h0B);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_an", {4'h0, an}, 8'h0F);
        chk("async_reset_seg", {1'b0, seg}, 8'h7F);
        chk("async_reset_dp", {7'h0, dp}, 8'h01);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        e   = 0;
        step(); step(); step();
        chk("restart_an", {4'h0, an}, 8'h0E);
        chk("restart_seg", {1'b0, seg}, 8'h40);
        repeat (2 * FRAME) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
